// File: rtl/ysyx_24080006_axi_pkg.sv
// rtl/ysyx_24080006_axi_pkg.sv - AXI4 read-channel request/response bundles
package ysyx_24080006_axi_pkg;

  typedef struct packed {
    logic        arvalid;
    logic [31:0] araddr;
    logic [3:0]  arid;
    logic [7:0]  arlen;
    logic [2:0]  arsize;
    logic [1:0]  arburst;
    logic        rready;
  } axi_r_m2s_t;

  typedef struct packed {
    logic        arready;
    logic        rvalid;
    logic [31:0] rdata;
    logic        rlast;
  } axi_r_s2m_t;

endpackage

// File: rtl/ysyx_24080006_rd_arbiter.sv
// rtl/ysyx_24080006_rd_arbiter.sv - IFU/LSU AXI4 read arbiter with burst length check
// Define YSYX_ARB_RR_EN for round-robin arbitration; default is fixed LSU-over-IFU priority.
module ysyx_24080006_rd_arbiter
  import ysyx_24080006_axi_pkg::*;
#(
  parameter logic [3:0] IFU_ID = 4'd0,
  parameter logic [3:0] LSU_ID = 4'd1
) (
  input  logic       clock,
  input  logic       reset,
  input  axi_r_m2s_t ifu_r_m2s,
  output axi_r_s2m_t ifu_r_s2m,
  input  axi_r_m2s_t lsu_r_m2s,
  output axi_r_s2m_t lsu_r_s2m,
  output axi_r_m2s_t core_r_m2s,
  input  axi_r_s2m_t core_r_s2m,
  output logic       busy,
  output logic       grant_lsu,
  output logic       len_err
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    AR   = 2'd1,
    R    = 2'd2
  } state_t;

  state_t     state, state_nxt;
  logic       grant, grant_nxt;
  logic [7:0] cnt, cnt_nxt;
  logic [7:0] len_q, len_nxt;
  logic       win;
  axi_r_m2s_t sel;
  axi_r_s2m_t rsp;

  assign sel = grant ? lsu_r_m2s : ifu_r_m2s;

`ifdef YSYX_ARB_RR_EN
  // ptr = 1 favours LSU; it only matters when both masters request together.
  logic ptr, ptr_nxt;
  assign win = (ifu_r_m2s.arvalid && lsu_r_m2s.arvalid) ? ptr : lsu_r_m2s.arvalid;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) ptr <= 1'b1;
    else        ptr <= ptr_nxt;
  end

  always_comb begin
    ptr_nxt = ptr;
    if (state == IDLE && (ifu_r_m2s.arvalid || lsu_r_m2s.arvalid)) ptr_nxt = ~win;
  end
`else
  assign win = lsu_r_m2s.arvalid;
`endif

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state <= IDLE;
      grant <= 1'b0;
      cnt   <= 8'd0;
      len_q <= 8'd0;
    end else begin
      state <= state_nxt;
      grant <= grant_nxt;
      cnt   <= cnt_nxt;
      len_q <= len_nxt;
    end
  end

  always_comb begin
    state_nxt  = state;
    grant_nxt  = grant;
    cnt_nxt    = cnt;
    len_nxt    = len_q;
    core_r_m2s = '0;
    rsp        = '0;
    len_err    = 1'b0;
    case (state)
      IDLE: begin
        if (ifu_r_m2s.arvalid || lsu_r_m2s.arvalid) begin
          grant_nxt = win;
          state_nxt = AR;
        end
      end
      AR: begin
        core_r_m2s        = sel;
        core_r_m2s.arid   = grant ? LSU_ID : IFU_ID;
        core_r_m2s.rready = 1'b0;
        rsp.arready       = core_r_s2m.arready;
        if (sel.arvalid && core_r_s2m.arready) begin
          len_nxt   = sel.arlen;
          cnt_nxt   = 8'd0;
          state_nxt = R;
        end
      end
      R: begin
        core_r_m2s.rready = sel.rready;
        rsp.rvalid        = core_r_s2m.rvalid;
        rsp.rdata         = core_r_s2m.rdata;
        rsp.rlast         = core_r_s2m.rlast;
        if (core_r_s2m.rvalid && sel.rready) begin
          cnt_nxt = cnt + 8'd1;
          // cnt holds beats already accepted, so the last beat must see cnt == arlen.
          if (core_r_s2m.rlast) begin
            len_err   = (cnt != len_q);
            state_nxt = IDLE;
          end else begin
            len_err = (cnt > len_q);
          end
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  assign ifu_r_s2m = grant ? '0 : rsp;
  assign lsu_r_s2m = grant ? rsp : '0;
  assign busy      = (state != IDLE);
  assign grant_lsu = grant;

endmodule

// File: tb/tb_ysyx_24080006_rd_arbiter.sv
// tb/tb_ysyx_24080006_rd_arbiter.sv - directed scoreboard bench for the read arbiter
module tb_ysyx_24080006_rd_arbiter;
  import ysyx_24080006_axi_pkg::*;

  logic       clock;
  logic       reset;
  axi_r_m2s_t ifu_m, lsu_m, core_m;
  axi_r_s2m_t ifu_s, lsu_s, core_s;
  logic       busy, grant_lsu, len_err;

  typedef struct {
    bit          lsu;
    logic [31:0] data;
    bit          last;
    bit          err;
  } exp_t;

  exp_t sb[$];
  int   total = 0;
  int   bad = 0;
  int   wait_n = 0;

  ysyx_24080006_rd_arbiter #(.IFU_ID(4'd0), .LSU_ID(4'd1)) dut (
    .clock(clock), .reset(reset),
    .ifu_r_m2s(ifu_m), .ifu_r_s2m(ifu_s),
    .lsu_r_m2s(lsu_m), .lsu_r_s2m(lsu_s),
    .core_r_m2s(core_m), .core_r_s2m(core_s),
    .busy(busy), .grant_lsu(grant_lsu), .len_err(len_err)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic axi_r_s2m_t pick(input bit lsu);
    return lsu ? lsu_s : ifu_s;
  endfunction

  task automatic set_req(input bit lsu, input logic [31:0] addr, input logic [7:0] len);
    axi_r_m2s_t r;
    r = '0;
    r.arvalid = 1'b1;
    r.araddr  = addr;
    r.arid    = 4'hf;
    r.arlen   = len;
    r.arsize  = 3'd2;
    r.arburst = 2'd1;
    if (lsu) lsu_m = r; else ifu_m = r;
  endtask

  task automatic set_rready(input bit lsu, input bit v);
    if (lsu) lsu_m.rready = v; else ifu_m.rready = v;
  endtask

  task automatic serve(input bit lsu, input logic [31:0] addr, input logic [7:0] len,
                       input int nbeats, input int last_at, input int err_at,
                       input bit gaps, input bit stall, input bit rearm);
    int   n;
    exp_t e;
    n = 0;
    do begin
      @(negedge clock);
      n++;
    end while (!core_m.arvalid && n < 20);
    wait_n = n;
    chk("ar_valid", core_m.arvalid, 1);
    chk("grant", grant_lsu, lsu);
    chk("arid", core_m.arid, lsu ? 4'd1 : 4'd0);
    chk("araddr", core_m.araddr, addr);
    chk("arlen", core_m.arlen, len);
    chk("arready_win", pick(lsu).arready, 1);
    chk("loser_ar", pick(!lsu), 0);
    chk("busy_ar", busy, 1);
    @(posedge clock); #1;
    if (lsu) lsu_m.arvalid = 1'b0; else ifu_m.arvalid = 1'b0;
    for (int b = 1; b <= nbeats; b++) begin
      if (gaps) begin
        core_s.rvalid = 1'b0;
        set_rready(lsu, 1'b1);
        @(negedge clock);
        chk("gap_rvalid", pick(lsu).rvalid, 0);
        chk("gap_err", len_err, 0);
        @(posedge clock); #1;
      end
      core_s.rvalid = 1'b1;
      core_s.rdata  = addr + 32'(b);
      core_s.rlast  = (b == last_at);
      e.lsu  = lsu;
      e.data = addr + 32'(b);
      e.last = (b == last_at);
      e.err  = (err_at != 0 && b >= err_at);
      sb.push_back(e);
      set_rready(lsu, !stall);
      if (stall) begin
        @(negedge clock);
        chk("stall_rvalid", pick(lsu).rvalid, 1);
        chk("stall_core_rready", core_m.rready, 0);
        chk("stall_err", len_err, 0);
        @(posedge clock); #1;
        set_rready(lsu, 1'b1);
      end
      @(negedge clock);
      chk("core_rready", core_m.rready, 1);
      chk("r_valid", pick(lsu).rvalid, 1);
      chk("sb_nonempty", sb.size() != 0, 1);
      if (sb.size() != 0) begin
        e = sb.pop_front();
        chk("r_data", pick(e.lsu).rdata, e.data);
        chk("r_last", pick(e.lsu).rlast, e.last);
        chk("len_err", len_err, e.err);
      end
      chk("loser_r", pick(!lsu), 0);
      @(posedge clock); #1;
      core_s.rvalid = 1'b0;
      core_s.rlast  = 1'b0;
      set_rready(lsu, 1'b0);
      if (rearm && b == nbeats) begin
        if (lsu) lsu_m.arvalid = 1'b1; else ifu_m.arvalid = 1'b1;
      end
    end
    if (!rearm) begin
      @(negedge clock);
      chk("busy_after", busy, 0);
      chk("core_idle", core_m, 0);
      @(posedge clock); #1;
    end
  endtask

  initial begin
    reset  = 1'b0;
    ifu_m  = '0;
    lsu_m  = '0;
    core_s = '0;
    core_s.arready = 1'b1;
    #1;
    chk("rst_ifu", ifu_s, 0);
    chk("rst_lsu", lsu_s, 0);
    chk("rst_core", core_m, 0);
    chk("rst_busy", busy, 0);
    chk("rst_grant", grant_lsu, 0);
    chk("rst_err", len_err, 0);
    #20;
    @(posedge clock); #1;
    reset = 1'b1;

    // single IFU fetch
    set_req(0, 32'h3000_0000, 8'd0);
    serve(0, 32'h3000_0000, 8'd0, 1, 1, 0, 0, 0, 0);
    chk("arb_latency", wait_n, 2);

    // LSU 4-beat burst with gaps and stalls
    set_req(1, 32'h8000_0100, 8'd3);
    serve(1, 32'h8000_0100, 8'd3, 4, 4, 0, 1, 1, 0);

    // early rlast, then missing rlast
    set_req(1, 32'h8000_0200, 8'd3);
    serve(1, 32'h8000_0200, 8'd3, 2, 2, 2, 0, 0, 0);
    set_req(0, 32'h3000_0300, 8'd1);
    serve(0, 32'h3000_0300, 8'd1, 4, 4, 3, 0, 0, 0);

    // reset asserted on beat 2 of 4
    set_req(1, 32'h8000_0400, 8'd3);
    wait_n = 0;
    do begin
      @(negedge clock);
      wait_n++;
    end while (!core_m.arvalid && wait_n < 20);
    chk("rstr_ar", core_m.arvalid, 1);
    @(posedge clock); #1;
    lsu_m.arvalid = 1'b0;
    lsu_m.rready  = 1'b1;
    core_s.rvalid = 1'b1;
    core_s.rdata  = 32'h1111_0001;
    @(negedge clock);
    chk("rstr_beat1", lsu_s.rdata, 32'h1111_0001);
    @(posedge clock); #1;
    core_s.rdata = 32'h1111_0002;
    @(negedge clock);
    chk("rstr_beat2_busy", busy, 1);
    reset = 1'b0;
    #1;
    chk("rstr_busy", busy, 0);
    chk("rstr_grant", grant_lsu, 0);
    chk("rstr_lsu", lsu_s, 0);
    chk("rstr_ifu", ifu_s, 0);
    chk("rstr_core", core_m, 0);
    chk("rstr_err", len_err, 0);
    @(posedge clock); #1;
    core_s.rvalid = 1'b0;
    lsu_m.rready  = 1'b0;
    reset = 1'b1;
    set_req(0, 32'h3000_0500, 8'd1);
    serve(0, 32'h3000_0500, 8'd1, 2, 2, 0, 0, 0, 0);

    // simultaneous requests, twice
    set_req(0, 32'h3000_0600, 8'd0);
    set_req(1, 32'h8000_0600, 8'd0);
    serve(1, 32'h8000_0600, 8'd0, 1, 1, 0, 0, 0, 1);
`ifdef YSYX_ARB_RR_EN
    serve(0, 32'h3000_0600, 8'd0, 1, 1, 0, 0, 0, 0);
    serve(1, 32'h8000_0600, 8'd0, 1, 1, 0, 0, 0, 0);
`else
    serve(1, 32'h8000_0600, 8'd0, 1, 1, 0, 0, 0, 0);
    serve(0, 32'h3000_0600, 8'd0, 1, 1, 0, 0, 0, 0);
`endif

    // back-to-back IFU requests
    set_req(0, 32'h3000_0700, 8'd0);
    serve(0, 32'h3000_0700, 8'd0, 1, 1, 0, 0, 0, 1);
    serve(0, 32'h3000_0700, 8'd0, 1, 1, 0, 0, 0, 0);
    chk("b2b_gap", wait_n, 2);

    chk("sb_empty", sb.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
